// File: rtl/serial_add_sub8.sv
// serial_add_sub8: bit-serial LSB-first adder/subtractor with valid/ready handshakes.
// One operand pair per transaction; result and carry (or not-borrow) come back after WIDTH shift cycles.
module serial_add_sub8 #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             busy
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             c_q, c_d, cout_q, cout_d;
    logic             accept, shifting, last, sum, carry;

    // Subtraction is a + ~b + ~cin, so b and the carry are inverted once at accept.
    always_comb begin
        accept   = (state_q == IDLE) && in_valid;
        shifting = state_q == SHIFT;
        last     = cnt_q == CNT_W'(WIDTH - 1);
        sum      = a_q[0] ^ b_q[0] ^ c_q;
        carry    = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
        state_d  = accept ? SHIFT :
                   (shifting && last) ? DONE :
                   (state_q == DONE && out_ready) ? IDLE : state_q;
        a_d      = accept ? a : shifting ? a_q >> 1 : a_q;
        b_d      = accept ? (op ? ~b : b) : shifting ? b_q >> 1 : b_q;
        c_d      = accept ? (op ? ~cin : cin) : shifting ? carry : c_q;
        cnt_d    = accept ? '0 : shifting ? cnt_q + CNT_W'(1) : cnt_q;
        res_d    = shifting ? {sum, res_q[WIDTH-1:1]} : res_q;
        cout_d   = (shifting && last) ? carry : cout_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            cout_q  <= cout_d;
        end
    end

    assign in_ready  = state_q == IDLE;
    assign busy      = state_q == SHIFT;
    assign out_valid = state_q == DONE;
    assign result    = res_q;
    assign cout      = cout_q;
endmodule

// File: tb/tb_serial_add_sub8.sv
// tb_serial_add_sub8: directed self-checking bench for serial_add_sub8.
module tb_serial_add_sub8;
    logic       clk = 1'b0;
    logic       rst, in_valid, in_ready, cin, op, out_valid, out_ready, cout, busy;
    logic [7:0] a, b, result;
    int         passed = 0;
    int         total = 0;

    serial_add_sub8 dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .op(op), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .cout(cout), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Independent reference: a - b - cin as a 9-bit difference, cout = not borrow.
    function automatic logic [8:0] model(input logic [7:0] x, input logic [7:0] y,
                                         input logic ci, input logic o);
        logic [8:0] d;
        if (o) begin
            d = {1'b0, x} - {1'b0, y} - {8'd0, ci};
            return {~d[8], d[7:0]};
        end
        return {1'b0, x} + {1'b0, y} + {8'd0, ci};
    endfunction

    task automatic do_op(input string tag, input logic [7:0] xa, input logic [7:0] xb,
                         input logic xc, input logic xo, input logic [8:0] exp, input int hold);
        int n;
        a = xa; b = xb; cin = xc; op = xo; in_valid = 1'b1;
        chk({tag, " in_ready idle"}, {8'd0, in_ready}, 9'd1);
        @(posedge clk); #1;
        chk({tag, " busy"}, {8'd0, busy}, 9'd1);
        chk({tag, " in_ready shift"}, {8'd0, in_ready}, 9'd0);
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); op = 1'($urandom);
            @(posedge clk); #1;
            n++;
        end
        chk({tag, " latency"}, 9'(n), 9'd8);
        chk({tag, " result"}, {cout, result}, exp);
        repeat (hold) begin
            @(posedge clk); #1;
            chk({tag, " hold"}, {out_valid, in_ready, busy, result}, {3'b100, exp[7:0]});
            chk({tag, " hold cout"}, {8'd0, cout}, {8'd0, exp[8]});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, " exit"}, {5'd0, out_valid, busy, in_ready, 1'b0}, 9'b000000010);
        chk({tag, " retained"}, {cout, result}, exp);
        in_valid = 1'b0;
        a = 'x; b = 'x; cin = 'x; op = 'x;
        @(posedge clk); #1;
    endtask

    initial begin
        logic       seen;
        logic [7:0] ra, rb;
        logic       rc, ro;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = 8'd0; b = 8'd0; cin = 1'b0; op = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset outs", {cout, result}, 9'd0);
        chk("reset flags", {6'd0, out_valid, busy, in_ready}, 9'b000000001);
        rst = 1'b0;
        @(posedge clk); #1;
        do_op("T1", 8'h37, 8'h05, 1'b1, 1'b0, 9'h03D, 0);
        do_op("T2", 8'hFF, 8'h00, 1'b1, 1'b0, 9'h100, 0);
        do_op("T3a", 8'h37, 8'h05, 1'b0, 1'b1, 9'h132, 0);
        do_op("T3b", 8'h30, 8'h06, 1'b0, 1'b1, 9'h12A, 0);
        do_op("T3c", 8'hFF, 8'h00, 1'b0, 1'b1, 9'h1FF, 0);
        do_op("T4a", 8'h00, 8'h01, 1'b0, 1'b1, 9'h0FF, 0);
        do_op("T4b", 8'h70, 8'h08, 1'b1, 1'b1, 9'h167, 0);
        do_op("T5", 8'hA5, 8'h5A, 1'b0, 1'b0, 9'h0FF, 10);
        a = 8'h12; b = 8'h34; cin = 1'b0; op = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("T6 rst outs", {cout, result}, 9'd0);
        chk("T6 rst flags", {7'd0, out_valid, busy}, 9'd0);
        @(posedge clk); #1 rst = 1'b0;
        chk("T6 in_ready", {8'd0, in_ready}, 9'd1);
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            seen |= out_valid;
        end
        chk("T6 no out_valid", {8'd0, seen}, 9'd0);
        do_op("T6 next", 8'h6E, 8'h03, 1'b1, 1'b0, 9'h072, 0);
        for (int i = 0; i < 6; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom); ro = 1'(i & 1);
            do_op("rand", ra, rb, rc, ro, model(ra, rb, rc, ro), i);
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
